// File: rtl/inertial_pkg.sv
// Shared FSM state type and default tuning constants for the inertial integrator.
package inertial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_UPD,
    S_DONE
  } state_e;

  localparam logic [15:0] DEF_RATE_OFFSET = 16'h0050;
  localparam logic [15:0] DEF_ACC_OFFSET  = 16'h00A0;
  localparam int          DEF_ACC_GAIN    = 327;
  localparam int          DEF_FUSE_STEP   = 1024;

endpackage

// File: rtl/sat_accum.sv
// Saturating y = a - b + c on IW-bit signed operands, computed two bits wider.
module sat_accum #(
  parameter int IW = 27
) (
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  input  logic signed [IW-1:0] c,
  output logic signed [IW-1:0] y
);

  localparam logic signed [IW+1:0] MAXV = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] MINV = {3'b111, {(IW-1){1'b0}}};

  logic signed [IW+1:0] wide;

  always_comb begin
    wide = (IW+2)'(a) - (IW+2)'(b) + (IW+2)'(c);
    if (wide > MAXV) begin
      y = MAXV[IW-1:0];
    end else if (wide < MINV) begin
      y = MINV[IW-1:0];
    end else begin
      y = wide[IW-1:0];
    end
  end

endmodule

// File: rtl/inertial_integrator_mc.sv
// Multi-channel gyro integrator with accelerometer leak fusion; one shared
// multiplier walks the channels in a MUL/UPD pair per channel.
module inertial_integrator_mc
  import inertial_pkg::*;
#(
  parameter int           NCH         = 2,
  parameter int           W           = 16,
  parameter int           FRAC        = 11,
  parameter logic [W-1:0] RATE_OFFSET = DEF_RATE_OFFSET,
  parameter logic [W-1:0] ACC_OFFSET  = DEF_ACC_OFFSET,
  parameter int           ACC_GAIN    = DEF_ACC_GAIN,
  parameter int           FUSE_STEP   = DEF_FUSE_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [NCH*W-1:0] rate,
  input  logic [NCH*W-1:0] acc,
  input  logic             fuse_en,
  input  logic             clr_ovr,
  output logic [NCH*W-1:0] angle,
  output logic             angle_vld,
  output logic             busy,
  output logic             ovr
);

  localparam int IW = W + FRAC;
  localparam int PW = W + 10;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [NCH*W-1:0]      rate_q, rate_d;
  logic [NCH*W-1:0]      acc_q, acc_d;
  logic                  fuse_q, fuse_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic signed [IW-1:0]  integ_q [NCH];
  logic signed [IW-1:0]  integ_d [NCH];
  logic                  ovr_q, ovr_d;

  logic [W-1:0]          acc_diff, rate_comp;
  logic signed [PW-1:0]  prod_mul;
  logic signed [W-1:0]   acc_ang, angle_cur;
  logic signed [IW-1:0]  integ_cur, rate_ext, leak, integ_upd;

  always_comb begin
    acc_diff  = acc_q[ch_q*W +: W] - ACC_OFFSET;
    rate_comp = rate_q[ch_q*W +: W] - RATE_OFFSET;
    prod_mul  = PW'($signed(acc_diff)) * PW'(ACC_GAIN);
    acc_ang   = W'(prod_q >>> 13);
    integ_cur = integ_q[ch_q];
    angle_cur = $signed(integ_cur[IW-1:FRAC]);
    rate_ext  = IW'($signed(rate_comp));
    leak      = '0;
    if (fuse_q) begin
      leak = (acc_ang > angle_cur) ? IW'(FUSE_STEP) : -IW'(FUSE_STEP);
    end
  end

  sat_accum #(.IW(IW)) u_sat_accum (
    .a (integ_cur),
    .b (rate_ext),
    .c (leak),
    .y (integ_upd)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rate_d  = rate_q;
    acc_d   = acc_q;
    fuse_d  = fuse_q;
    prod_d  = prod_q;
    integ_d = integ_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (vld) begin
          rate_d  = rate;
          acc_d   = acc;
          fuse_d  = fuse_en;
          ch_d    = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = prod_mul;
        state_d = S_UPD;
      end
      S_UPD: begin
        integ_d[ch_q] = integ_upd;
        if (ch_q == CW'(NCH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A dropped sample in the same cycle as a clear must stay visible.
    if (clr_ovr) ovr_d = 1'b0;
    if (vld && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      rate_q  <= '0;
      acc_q   <= '0;
      fuse_q  <= 1'b0;
      prod_q  <= '0;
      ovr_q   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) integ_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rate_q  <= rate_d;
      acc_q   <= acc_d;
      fuse_q  <= fuse_d;
      prod_q  <= prod_d;
      ovr_q   <= ovr_d;
      integ_q <= integ_d;
    end
  end

  always_comb begin
    angle = '0;
    for (int unsigned i = 0; i < NCH; i++) angle[i*W +: W] = integ_q[i][IW-1:FRAC];
  end

  assign angle_vld = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_inertial_integrator_mc.sv
// Scoreboard bench for inertial_integrator_mc at NCH=2 and default parameters.
module tb_inertial_integrator_mc;

  localparam int NCH = 2;
  localparam int W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld;
  logic [NCH*W-1:0] rate;
  logic [NCH*W-1:0] acc;
  logic             fuse_en;
  logic             clr_ovr;
  logic [NCH*W-1:0] angle;
  logic             angle_vld;
  logic             busy;
  logic             ovr;

  int n_cmp = 0;
  int n_err = 0;

  logic [NCH*W-1:0] exp_q[$];
  longint           model_integ [NCH];

  inertial_integrator_mc #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .rate      (rate),
    .acc       (acc),
    .fuse_en   (fuse_en),
    .clr_ovr   (clr_ovr),
    .angle     (angle),
    .angle_vld (angle_vld),
    .busy      (busy),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one accepted sample; returns the expected angle bus.
  function automatic logic [NCH*W-1:0] model_step(input logic [NCH*W-1:0] r,
                                                  input logic [NCH*W-1:0] a, input bit f);
    logic [NCH*W-1:0]   res;
    logic signed [15:0] rc, d;
    longint             prod, aang, ang, leak, nxt;
    res = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      rc   = r[ch*W +: W] - 16'h0050;
      d    = a[ch*W +: W] - 16'h00A0;
      prod = longint'(d) * 327;
      aang = prod >>> 13;
      ang  = model_integ[ch] >>> 11;
      leak = f ? ((aang > ang) ? 1024 : -1024) : 0;
      nxt  = model_integ[ch] - longint'(rc) + leak;
      if (nxt > (64'sd1 <<< 26) - 1) nxt = (64'sd1 <<< 26) - 1;
      if (nxt < -(64'sd1 <<< 26))    nxt = -(64'sd1 <<< 26);
      model_integ[ch] = nxt;
      res[ch*W +: W] = 16'(nxt >>> 11);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (angle_vld) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_vld", angle_vld, 1'b0);
      end else begin
        check_eq("angle", angle, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int ch = 0; ch < NCH; ch++) model_integ[ch] = 0;
    exp_q.delete();
  endtask

  task automatic send(input logic [NCH*W-1:0] r, input logic [NCH*W-1:0] a, input bit f);
    int n;
    exp_q.push_back(model_step(r, a, f));
    rate = r; acc = a; fuse_en = f; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    rate = $urandom; acc = $urandom; fuse_en = 1'($urandom);
    n = 1;
    while (!angle_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 64'(n), 64'd5);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = 1'b0; rate = '0; acc = '0; fuse_en = 1'b0; clr_ovr = 1'b0;
    @(negedge clk);
    do_reset();
    check_eq("rst_angle", angle, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ovr", ovr, 1'b0);
    check_eq("rst_vld", angle_vld, 1'b0);

    send({16'h0050, 16'h0050}, {16'h00A0, 16'h00A0}, 1'b0);

    for (int i = 0; i < 3; i++) begin
      send({16'h0050, 16'hF850}, {16'h00A0, 16'h00A0}, 1'b0);
      repeat (3) @(negedge clk);
    end

    do_reset();
    send({16'h0050, 16'h0050}, {16'h10A0, 16'h10A0}, 1'b1);
    send({16'h0050, 16'h0050}, {16'h10A0, 16'h10A0}, 1'b1);

    // Overrun: second vld arrives mid-sample together with clr_ovr.
    do_reset();
    exp_q.push_back(model_step({16'h0050, 16'hF850}, {16'h00A0, 16'h00A0}, 1'b0));
    rate = {16'h0050, 16'hF850}; acc = {16'h00A0, 16'h00A0}; fuse_en = 1'b0; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    vld = 1'b1; clr_ovr = 1'b1; rate = {16'h8050, 16'h8050};
    @(negedge clk);
    vld = 1'b0; clr_ovr = 1'b0;
    check_eq("ovr_set_wins", ovr, 1'b1);
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    check_eq("ovr_busy_done", busy, 1'b0);
    check_eq("ovr_sticky", ovr, 1'b1);
    check_eq("ovr_single_upd", angle, {16'h0000, 16'h0001});
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check_eq("ovr_cleared", ovr, 1'b0);

    // Reset while the first channel is in MUL aborts the sample.
    rate = {16'h0050, 16'hF850}; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    check_eq("abort_busy_before", busy, 1'b1);
    do_reset();
    repeat (10) @(negedge clk);
    check_eq("abort_angle", angle, '0);
    check_eq("abort_busy", busy, 1'b0);

    do_reset();
    for (int i = 0; i < 2050; i++) send({16'h8050, 16'h8050}, {16'h00A0, 16'h00A0}, 1'b0);
    check_eq("sat_angle", angle, {16'h7FFF, 16'h7FFF});
    check_eq("sat_integ", 64'(dut.integ_q[0]), 64'((64'd1 << 26) - 1));

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
